imem_loader: RTL

- Boot-time program loader that sits directly upstream of the CPU's instruction memory.
- Accepts a byte stream over a valid/ready interface, for example from a UART receiver, and assembles little-endian 32-bit instruction words.
- Writes each word into the instruction ROM's write port at consecutive word addresses.
- Holds the CPU in reset until the full program is written. This replaces preloading the ROM from a bench, so hardware can boot new programs.

---
 rtl/imem_loader.sv | 122 ++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// Boot-time loader: assembles a byte stream into little-endian 32-bit words,
// writes them into instruction memory and holds the CPU in reset until done.
module imem_loader #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  reload,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_waddr,
    output logic [31:0]           imem_wdata,
    output logic                  cpu_rst,
    output logic                  done,
    output logic                  error
);

    typedef enum logic [2:0] {
        LEN_LO,
        LEN_HI,
        DATA,
        DONE,
        ERROR
    } state_t;

    localparam logic [16:0] DEPTH = 17'(2 ** ADDR_WIDTH);

    state_t              r_state;
    logic [15:0]         r_count;
    logic [1:0]          r_byte_idx;
    logic [ADDR_WIDTH:0] r_word_idx;
    logic [23:0]         r_buf;

    logic                w_accept;
    logic [16:0]         w_hdr_count;
    logic [16:0]         w_next_word;

    assign in_ready    = (r_state == LEN_LO) || (r_state == LEN_HI) || (r_state == DATA);
    assign w_accept    = in_valid && in_ready;
    // Full header value as it becomes known on the LEN_HI accept edge.
    assign w_hdr_count = {1'b0, in_data, r_count[7:0]};
    assign w_next_word = 17'(r_word_idx) + 17'd1;

    // NOTE: all state below uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would chain updates within a cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= LEN_LO;
            r_count    <= '0;
            r_byte_idx <= '0;
            r_word_idx <= '0;
            r_buf      <= '0;
            imem_we    <= 1'b0;
            imem_waddr <= '0;
            imem_wdata <= '0;
            cpu_rst    <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            case (r_state)
                LEN_LO: begin
                    if (w_accept) begin
                        r_count[7:0] <= in_data;
                        r_state      <= LEN_HI;
                    end
                end
                LEN_HI: begin
                    if (w_accept) begin
                        r_count[15:8] <= in_data;
                        r_byte_idx    <= '0;
                        r_word_idx    <= '0;
                        if (w_hdr_count == 17'd0) begin
                            r_state <= DONE;
                        end else if (w_hdr_count > DEPTH) begin
                            r_state <= ERROR;
                        end else begin
                            r_state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (w_accept) begin
                        r_byte_idx <= r_byte_idx + 2'd1;
                        if (r_byte_idx != 2'd3) begin
                            r_buf[8*r_byte_idx +: 8] <= in_data;
                        end else begin
                            imem_we    <= 1'b1;
                            imem_wdata <= {in_data, r_buf};
                            imem_waddr <= r_word_idx[ADDR_WIDTH-1:0];
                            r_word_idx <= r_word_idx + 1'b1;
                            if (w_next_word == {1'b0, r_count}) begin
                                r_state <= DONE;
                            end
                        end
                    end
                end
                DONE: begin
                    if (reload) begin
                        r_state    <= LEN_LO;
                        r_count    <= '0;
                        r_byte_idx <= '0;
                        r_word_idx <= '0;
                        cpu_rst    <= 1'b1;
                        done       <= 1'b0;
                    end else begin
                        cpu_rst <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                ERROR: begin
                    error   <= 1'b1;
                    cpu_rst <= 1'b1;
                end
                default: r_state <= LEN_LO;
            endcase
        end
    end

endmodule
